mem_sub_xfer_ctrl: RTL

- Sequences a memory-to-memory transfer through the 8-bit Subtracter datapath.
- For each index i in 0..len-1: reads mem1[i] and mem2[i], presents them to the Subtracter (DOut2 = mem2 word = minuend, DOut1 = mem1 word = subtrahend), then writes SUBOut into mem2 at DST_OFF+i.
- Sits between the top-level start/done handshake and the two synchronous-read memories plus the Subtracter instance.

---
 rtl/mem_sub_xfer_ctrl_pkg.sv | 16 +
 rtl/mem_sub_xfer_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/mem_sub_xfer_ctrl_pkg.sv
// Shared definitions for the memory-to-memory subtract transfer controller.
// Holds the FSM state encoding and the default datapath widths.
package mem_sub_xfer_ctrl_pkg;

  localparam int unsigned DefDw = 8;
  localparam int unsigned DefAw = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCap,
    StWr,
    StFin
  } xfer_state_e;

endpackage

// File: rtl/mem_sub_xfer_ctrl.sv
// Sequences mem1/mem2 reads through an external Subtracter and writes each
// difference back into mem2 at a fixed offset, three cycles per element.
module mem_sub_xfer_ctrl
  import mem_sub_xfer_ctrl_pkg::*;
#(
  parameter int unsigned DW      = DefDw,
  parameter int unsigned AW      = DefAw,
  parameter int unsigned DST_OFF = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic [AW-1:0] mem1_addr,
  output logic          mem1_rd,
  input  logic [DW-1:0] mem1_dout,
  output logic [AW-1:0] mem2_addr,
  output logic          mem2_rd,
  output logic          mem2_wr,
  output logic [DW-1:0] mem2_din,
  input  logic [DW-1:0] mem2_dout,
  output logic [DW-1:0] DOut2,
  output logic [DW-1:0] DOut1,
  input  logic [DW-1:0] SUBOut,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] DstOff = AW'(DST_OFF);
  localparam logic [AW:0]   IdxOne = (AW + 1)'(1);

  xfer_state_e   state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [DW-1:0] dout1_q, dout1_d;
  logic [DW-1:0] dout2_q, dout2_d;
  logic          rd_en, wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      dout1_q <= '0;
      dout2_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dout1_q <= dout1_d;
      dout2_q <= dout2_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    dout1_d   = dout1_q;
    dout2_d   = dout2_q;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    mem1_addr = '0;
    mem2_addr = '0;
    mem2_din  = '0;
    done      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = len;
          idx_d   = '0;
          state_d = (len == '0) ? StFin : StRd;
        end
      end
      StRd: begin
        rd_en     = 1'b1;
        mem1_addr = idx_q[AW-1:0];
        mem2_addr = idx_q[AW-1:0];
        state_d   = StCap;
      end
      StCap: begin
        dout2_d = mem2_dout;
        dout1_d = mem1_dout;
        state_d = StWr;
      end
      StWr: begin
        wr_en     = 1'b1;
        mem2_addr = DstOff + idx_q[AW-1:0];
        mem2_din  = SUBOut;
        idx_d     = idx_q + IdxOne;
        // AW+1-bit compare so len = 2^AW runs the full address space
        state_d   = (idx_d == cnt_q) ? StFin : StRd;
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset aborts at once: no memory access in the reset cycle itself
  assign mem1_rd = rd_en & ~rst;
  assign mem2_rd = rd_en & ~rst;
  assign mem2_wr = wr_en & ~rst;

  assign busy  = (state_q != StIdle);
  assign DOut2 = dout2_q;
  assign DOut1 = dout1_q;

endmodule
